// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the main-RAM arbiter: address width, FSM encodings, requester indices.
package ram_arbiter_pkg;

    localparam int RAM_ADDR_BITS = 10;
    localparam int RAM_ADDR_MAX  = (1 << RAM_ADDR_BITS) - 1;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_WAIT_RD = 2'd2,
        ARB_RESP    = 2'd3
    } arb_state_e;

    localparam int REQ_INIT   = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_DFETCH = 2;
    localparam int REQ_IFETCH = 3;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select over the eligible vector; one-hot result plus valid flag.
// RAM_ARB_RR_EN: round-robin search starting after ptr_i; otherwise lowest index wins.
module ram_arb_pick
    import ram_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] elig_i,
`ifdef RAM_ARB_RR_EN
    input  logic [PW-1:0]   ptr_i,
`endif
    output logic [NREQ-1:0] win_oh_o,
    output logic            win_valid_o
);

`ifdef RAM_ARB_RR_EN
    logic [PW-1:0] idx;

    always_comb begin
        win_oh_o    = '0;
        win_valid_o = 1'b0;
        idx         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr_i) + k) % NREQ);
            if (!win_valid_o && elig_i[idx]) begin
                win_oh_o[idx] = 1'b1;
                win_valid_o   = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win_oh_o    = '0;
        win_valid_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_valid_o && elig_i[k]) begin
                win_oh_o[k] = 1'b1;
                win_valid_o = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Main-RAM arbiter: one access in flight, read data returned to its owner with a strobe.
// Build option RAM_ARB_RR_EN selects round-robin arbitration (default: fixed priority).
//
// state       | meaning
// ARB_IDLE    | waiting for an eligible request; a grant launches the RAM strobe
// ARB_ISSUE   | RAM strobe and req_ready visible for their single cycle
// ARB_WAIT_RD | counting down remaining read latency
// ARB_RESP    | RAM read data valid; captured and routed to the owner
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int RD_LAT = 1,
    parameter int AW     = RAM_ADDR_BITS
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_mask_i,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ-1:0]    req_we_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*4-1:0]  req_byteen_i,
    input  logic [NREQ*32-1:0] req_wrdata_i,
    output logic [NREQ-1:0]    req_ready_o,
    output logic [NREQ-1:0]    rsp_valid_o,
    output logic [31:0]        rsp_rddata_o,
    output logic [AW-1:0]      ram_addr_o,
    output logic [3:0]         ram_byteen_o,
    output logic [31:0]        ram_wrdata_o,
    output logic               ram_rden_o,
    output logic               ram_wren_o,
    input  logic [31:0]        ram_rddata_i,
    output logic               busy_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 2;

    arb_state_e      state_q;
    logic [NREQ-1:0] owner_q;
    logic [NREQ-1:0] req_ready_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [31:0]     rsp_rddata_q;
    logic [AW-1:0]   ram_addr_q;
    logic [3:0]      ram_byteen_q;
    logic [31:0]     ram_wrdata_q;
    logic            ram_rden_q;
    logic            ram_wren_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] win_oh;
    logic            win_valid;
    logic [AW-1:0]   win_addr;
    logic [3:0]      win_be;
    logic [31:0]     win_wd;
    logic            win_we;

`ifdef RAM_ARB_RR_EN
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   win_idx;
`endif

    assign elig  = req_valid_i & req_mask_i;
    assign cnt_d = cnt_q - CW'(1);

    ram_arb_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .elig_i      (elig),
`ifdef RAM_ARB_RR_EN
        .ptr_i       (ptr_q),
`endif
        .win_oh_o    (win_oh),
        .win_valid_o (win_valid)
    );

    always_comb begin
        win_addr = '0;
        win_be   = '0;
        win_wd   = '0;
        win_we   = 1'b0;
`ifdef RAM_ARB_RR_EN
        win_idx  = '0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_addr = req_addr_i[i*AW +: AW];
                win_be   = req_byteen_i[i*4 +: 4];
                win_wd   = req_wrdata_i[i*32 +: 32];
                win_we   = req_we_i[i];
`ifdef RAM_ARB_RR_EN
                win_idx  = PW'(i);
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_rddata_q <= '0;
            ram_addr_q   <= '0;
            ram_byteen_q <= '0;
            ram_wrdata_q <= '0;
            ram_rden_q   <= 1'b0;
            ram_wren_q   <= 1'b0;
            cnt_q        <= '0;
`ifdef RAM_ARB_RR_EN
            ptr_q        <= PW'(NREQ - 1);
`endif
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            unique case (state_q)
                ARB_IDLE: begin
                    if (win_valid) begin
                        ram_addr_q   <= win_addr;
                        ram_byteen_q <= win_we ? win_be : 4'hf;
                        ram_wrdata_q <= win_wd;
                        ram_wren_q   <= win_we;
                        ram_rden_q   <= ~win_we;
                        req_ready_q  <= win_oh;
                        owner_q      <= win_oh;
                        state_q      <= ARB_ISSUE;
`ifdef RAM_ARB_RR_EN
                        ptr_q        <= win_idx;
`endif
                    end
                end
                ARB_ISSUE: begin
                    ram_rden_q <= 1'b0;
                    ram_wren_q <= 1'b0;
                    // ram_wren_q still holds the launched op type during this cycle
                    if (ram_wren_q) begin
                        state_q <= ARB_IDLE;
                    end else if (RD_LAT <= 1) begin
                        state_q <= ARB_RESP;
                    end else begin
                        cnt_q   <= CW'(RD_LAT - 1);
                        state_q <= ARB_WAIT_RD;
                    end
                end
                ARB_WAIT_RD: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == '0) begin
                        state_q <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    rsp_rddata_q <= ram_rddata_i;
                    rsp_valid_q  <= owner_q;
                    state_q      <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rddata_o = rsp_rddata_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_byteen_o = ram_byteen_q;
    assign ram_wrdata_o = ram_wrdata_q;
    assign ram_rden_o   = ram_rden_q;
    assign ram_wren_o   = ram_wren_q;
    assign busy_o       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: three instances (RD_LAT 1..3), each with its own RAM model.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int AW = RAM_ADDR_BITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [3:0]      mask = '0;
    logic [3:0]      we   = '0;
    logic [4*AW-1:0] addr = '0;
    logic [15:0]     be   = '0;
    logic [127:0]    wd   = '0;
    logic [3:0]      valid_v [3];

    logic [3:0]    rdy   [3];
    logic [3:0]    rsv   [3];
    logic [31:0]   rdata [3];
    logic [AW-1:0] raddr [3];
    logic [3:0]    rbe   [3];
    logic [31:0]   rwd   [3];
    logic          rden  [3];
    logic          wren  [3];
    logic [31:0]   ramrd [3];
    logic          busy  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ram_arbiter #(.NREQ(4), .RD_LAT(g + 1)) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .req_mask_i   (mask),
            .req_valid_i  (valid_v[g]),
            .req_we_i     (we),
            .req_addr_i   (addr),
            .req_byteen_i (be),
            .req_wrdata_i (wd),
            .req_ready_o  (rdy[g]),
            .rsp_valid_o  (rsv[g]),
            .rsp_rddata_o (rdata[g]),
            .ram_addr_o   (raddr[g]),
            .ram_byteen_o (rbe[g]),
            .ram_wrdata_o (rwd[g]),
            .ram_rden_o   (rden[g]),
            .ram_wren_o   (wren[g]),
            .ram_rddata_i (ramrd[g]),
            .busy_o       (busy[g])
        );

        logic [31:0] mem  [1024];
        logic [31:0] pipe [3];
        logic [31:0] bmask;
        assign bmask = {{8{rbe[g][3]}}, {8{rbe[g][2]}}, {8{rbe[g][1]}}, {8{rbe[g][0]}}};

        always @(posedge clk) begin
            if (wren[g]) mem[raddr[g]] <= (mem[raddr[g]] & ~bmask) | (rwd[g] & bmask);
            if (rden[g]) pipe[0] <= mem[raddr[g]];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign ramrd[g] = pipe[g];
    end

    task automatic set_req(input int r, input logic w, input logic [AW-1:0] a,
                           input logic [3:0] b, input logic [31:0] d);
        we[r]            = w;
        addr[r*AW +: AW] = a;
        be[r*4 +: 4]     = b;
        wd[r*32 +: 32]   = d;
    endtask

    task automatic wait_ready(input int g, input int r, output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rdy[g][r]) begin
                at = cyc;
                valid_v[g][r] = 1'b0;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int g, output int at, output logic [3:0] vec, output logic [31:0] data);
        at   = -1;
        vec  = '0;
        data = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rsv[g] != 4'b0) begin
                at   = cyc;
                vec  = rsv[g];
                data = rdata[g];
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rdy[0] !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", rdy[0]); end
        checks++; if (rsv[0] !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsv[0]); end
        checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL reset_rddata: got %h want 0", rdata[0]); end
        checks++; if ({raddr[0], rbe[0], rwd[0]} !== '0) begin errors++; $display("FAIL reset_ram_bus: got %h/%h/%h want 0", raddr[0], rbe[0], rwd[0]); end
        checks++; if ({rden[0], wren[0], busy[0]} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got rden=%b wren=%b busy=%b want 0", rden[0], wren[0], busy[0]); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b want 0", busy[0]); end
    endtask

    task automatic test_write_read();
        int t_rdy, t_rsp;
        bit ok;
        logic [3:0] vec;
        logic [31:0] data;
        mask = 4'hf;
        set_req(1, 1'b1, 10'd5, 4'hf, 32'hdead0005);
        valid_v[0] = 4'b0010;
        wait_ready(0, 1, t_rdy, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_ready_timeout: got no ready want ready[1]"); end
        checks++; if ({wren[0], rden[0]} !== 2'b10) begin errors++; $display("FAIL wr_strobe: got wren=%b rden=%b want 1/0", wren[0], rden[0]); end
        checks++; if (raddr[0] !== 10'd5) begin errors++; $display("FAIL wr_addr: got %0d want 5", raddr[0]); end
        checks++; if (rwd[0] !== 32'hdead0005) begin errors++; $display("FAIL wr_data: got %h want dead0005", rwd[0]); end
        @(negedge clk);
        checks++; if ({wren[0], busy[0]} !== 2'b00) begin errors++; $display("FAIL wr_one_cycle: got wren=%b busy=%b want 0/0", wren[0], busy[0]); end
        set_req(1, 1'b0, 10'd5, 4'h3, 32'h0);
        valid_v[0] = 4'b0010;
        wait_ready(0, 1, t_rdy, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rd_ready_timeout: got no ready want ready[1]"); end
        checks++; if ({rden[0], rbe[0]} !== 5'b1_1111) begin errors++; $display("FAIL rd_strobe_be: got rden=%b be=%h want 1/f", rden[0], rbe[0]); end
        wait_rsp(0, t_rsp, vec, data);
        checks++; if (t_rsp - t_rdy !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", t_rsp - t_rdy); end
        checks++; if (vec !== 4'b0010) begin errors++; $display("FAIL rd_owner: got %b want 0010", vec); end
        checks++; if (data !== 32'hdead0005) begin errors++; $display("FAIL rd_data: got %h want dead0005", data); end
    endtask

    task automatic test_contention();
        int t_rdy, ng, pend, idx;
        bit ok;
        int exp_order [4];
        logic [3:0] exp_v;
`ifdef RAM_ARB_RR_EN
        exp_order = '{1, 2, 3, 0};
`else
        exp_order = '{0, 1, 2, 3};
`endif
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, AW'(10 + i), 4'hf, 32'hc0de0000 + 32'(i));
            valid_v[0] = 4'b0001;
            wait_ready(0, 0, t_rdy, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL preload_timeout: entry %0d got no ready", i); end
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, AW'(10 + i), 4'hf, 32'h0);
        valid_v[0] = 4'hf;
        ng = 0;
        pend = -1;
        for (int n = 0; n < 60 && !(ng == 4 && pend < 0); n++) begin
            @(negedge clk);
            if (rsv[0] != 4'b0) begin
                exp_v = (pend >= 0) ? (4'b0001 << pend) : 4'b0000;
                checks++; if (rsv[0] !== exp_v) begin errors++; $display("FAIL cont_rsp_owner: got %b want %b", rsv[0], exp_v); end
                if (pend >= 0) begin
                    checks++; if (rdata[0] !== 32'hc0de0000 + 32'(pend)) begin errors++; $display("FAIL cont_rsp_data: got %h want %h", rdata[0], 32'hc0de0000 + 32'(pend)); end
                end
                pend = -1;
            end
            if (rdy[0] != 4'b0) begin
                checks++; if (pend >= 0) begin errors++; $display("FAIL cont_overlap: got grant %b while %0d pending want none", rdy[0], pend); end
                exp_v = (ng < 4) ? (4'b0001 << exp_order[ng]) : 4'b0000;
                checks++; if (rdy[0] !== exp_v) begin errors++; $display("FAIL cont_order: grant %0d got %b want %b", ng, rdy[0], exp_v); end
                idx = 0;
                for (int i = 0; i < 4; i++) if (rdy[0][i]) idx = i;
                pend = idx;
                valid_v[0] = valid_v[0] & ~rdy[0];
                ng++;
            end
        end
        checks++; if (ng !== 4) begin errors++; $display("FAIL cont_grant_count: got %0d want 4", ng); end
        valid_v[0] = 4'b0;
    endtask

    task automatic test_arbitration();
        logic [3:0] got [4];
        logic [3:0] exp_g [4];
        int ng;
`ifdef RAM_ARB_RR_EN
        exp_g = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
`else
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        for (int k = 0; k < 4; k++) got[k] = 4'b0;
        set_req(0, 1'b0, 10'd10, 4'hf, 32'h0);
        set_req(2, 1'b0, 10'd12, 4'hf, 32'h0);
        valid_v[0] = 4'b0101;
        ng = 0;
        for (int n = 0; n < 40 && ng < 4; n++) begin
            @(negedge clk);
            if (rdy[0] != 4'b0) begin
                got[ng] = rdy[0];
                ng++;
            end
        end
        valid_v[0] = 4'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++; if (got[k] !== exp_g[k]) begin errors++; $display("FAIL arb_grant_%0d: got %b want %b", k, got[k], exp_g[k]); end
        end
    endtask

    task automatic test_masking();
        int t_rdy, t_rsp, bad;
        bit ok;
        logic [3:0] vec;
        logic [31:0] data;
        set_req(0, 1'b0, 10'd10, 4'hf, 32'h0);
        set_req(3, 1'b0, 10'd13, 4'hf, 32'h0);
        mask = 4'b0001;
        valid_v[0] = 4'b1001;
        wait_ready(0, 0, t_rdy, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mask_req0_timeout: got no ready want ready[0]"); end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rdy[0][3]) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mask_blocked: got %0d grants to 3 want 0", bad); end
        mask = 4'b1000;
        wait_ready(0, 3, t_rdy, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mask_req3_timeout: got no ready want ready[3]"); end
        mask = 4'b0000;
        wait_rsp(0, t_rsp, vec, data);
        checks++; if (vec !== 4'b1000) begin errors++; $display("FAIL mask_inflight_rsp: got %b want 1000", vec); end
        checks++; if (data !== 32'hc0de0003) begin errors++; $display("FAIL mask_inflight_data: got %h want c0de0003", data); end
        mask = 4'hf;
    endtask

    task automatic test_withdraw();
        int t_rdy, bad;
        bit ok;
        set_req(0, 1'b0, 10'd10, 4'hf, 32'h0);
        set_req(2, 1'b0, 10'd12, 4'hf, 32'h0);
        valid_v[0] = 4'b0101;
        wait_ready(0, 0, t_rdy, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wd_req0_timeout: got no ready want ready[0]"); end
        valid_v[0][2] = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rdy[0][2] || rsv[0][2]) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL wd_no_ready: got %0d strobes to 2 want 0", bad); end
    endtask

    task automatic test_latency_sweep();
        int first, second, rsp1, gap;
        for (int g = 0; g < 3; g++) begin
            set_req(0, 1'b0, 10'd10, 4'hf, 32'h0);
            set_req(1, 1'b0, 10'd11, 4'hf, 32'h0);
            mask = 4'hf;
            valid_v[g] = 4'b0011;
            first = -1; second = -1; rsp1 = -1; gap = 0;
            for (int n = 0; n < 40 && second < 0; n++) begin
                @(negedge clk);
                if (first >= 0 && !busy[g]) gap++;
                if (rsv[g] != 4'b0 && rsp1 < 0) rsp1 = cyc;
                if (rdy[g] != 4'b0) begin
                    if (first < 0) first = cyc;
                    else second = cyc;
                    valid_v[g] = valid_v[g] & ~rdy[g];
                end
            end
            valid_v[g] = 4'b0;
            checks++; if (second - first !== g + 3) begin errors++; $display("FAIL sweep_occupancy_lat%0d: got %0d want %0d", g + 1, second - first, g + 3); end
            checks++; if (rsp1 - first !== g + 2) begin errors++; $display("FAIL sweep_rsp_lat%0d: got %0d want %0d", g + 1, rsp1 - first, g + 2); end
            checks++; if (gap !== 1) begin errors++; $display("FAIL sweep_busy_gap_lat%0d: got %0d want 1", g + 1, gap); end
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_access();
        int t_rdy, bad;
        bit ok;
        set_req(1, 1'b0, 10'd7, 4'hf, 32'h0);
        mask = 4'hf;
        valid_v[1] = 4'b0010;
        wait_ready(1, 1, t_rdy, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_ready_timeout: got no ready want ready[1]"); end
        @(negedge clk);
        checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL rstmid_in_wait: busy=%b want 1", busy[1]); end
        rst_n = 1'b0;
        #1;
        checks++; if ({busy[1], rden[1], wren[1]} !== 3'b000) begin errors++; $display("FAIL rstmid_strobes: got busy=%b rden=%b wren=%b want 0", busy[1], rden[1], wren[1]); end
        checks++; if (raddr[1] !== '0) begin errors++; $display("FAIL rstmid_addr: got %0d want 0", raddr[1]); end
        checks++; if ({rdy[1], rsv[1], rdata[1]} !== '0) begin errors++; $display("FAIL rstmid_outputs: got %b/%b/%h want 0", rdy[1], rsv[1], rdata[1]); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsv[1] != 4'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_no_rsp: got %0d responses want 0", bad); end
    endtask

    initial begin
        for (int g = 0; g < 3; g++) valid_v[g] = 4'b0;
        test_reset();
        test_write_read();
        test_contention();
        test_arbitration();
        test_masking();
        test_withdraw();
        test_latency_sweep();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single-port main RAM between several requesters: init sequencer, program loader, CPU fetch and CPU data. One access is issued to the RAM at a time. Read data is returned to the owning requester with a valid strobe. Sits between the top-level PPC state machine and the RAM macro, replacing per-state RAM muxing.

Parameters:
NREQ, 4, number of requesters; index 0 is highest fixed priority.
RD_LAT, 1, cycles from ram_rden asserted to ram_rddata valid (1..3).

Ports:
clk  in  1  clock
rst  in  1  reset; active-low, asynchronous
req_mask  in  NREQ  1 = requester eligible (driven from PPC state)
req_valid  in  NREQ  access request, held until req_ready
req_we  in  NREQ  1 = write, 0 = read
req_addr  in  NREQ*`RAM_ADDR_BITS  packed addresses, requester i at slice i
req_byteen  in  NREQ*4  packed byte enables
req_wrdata  in  NREQ*32  packed write data
req_ready  out  NREQ  one-cycle pulse: request accepted and issued
rsp_valid  out  NREQ  one-cycle pulse: rsp_rddata valid for that requester
rsp_rddata  out  32  read data, shared by all requesters
ram_addr  out  `RAM_ADDR_BITS  to RAM
ram_byteen  out  4  to RAM
ram_wrdata  out  32  to RAM
ram_rden  out  1  to RAM
ram_wren  out  1  to RAM
ram_rddata  in  32  from RAM
busy  out  1  1 while FSM not IDLE

Behaviour:
- Reset (rst low, async): FSM=IDLE; all outputs 0; last-grant pointer = NREQ-1.
- Eligible set = req_valid & req_mask. Requesters with req_mask=0 are never granted, even if valid.
- FSM states:
  - IDLE: if eligible set is nonzero, select winner w; latch w's addr/byteen/wrdata/we into ram_* registers; assert ram_wren or ram_rden for exactly one cycle; pulse req_ready[w]; go to ISSUE.
  - ISSUE: deassert ram_rden/ram_wren. On a write, go to IDLE. On a read, load the latency counter with RD_LAT-1 and go to WAIT_RD; if RD_LAT==1, go straight to RESP.
  - WAIT_RD: decrement the counter; at 0, go to RESP.
  - RESP: capture ram_rddata into rsp_rddata; pulse rsp_valid[w]; go to IDLE.
- Throughput: a write occupies 2 cycles (IDLE→ISSUE). A read occupies RD_LAT+2 cycles. The next grant can be issued in the cycle after RESP or write-ISSUE.
- rsp_rddata holds its value until the next read response. It is 0 after reset.
- req_valid dropped before req_ready: the request is silently withdrawn, and no ready pulse is sent.
- req_mask falls after a grant: the in-flight access completes normally, including its rsp_valid.
- req_valid and req_ready high in the same cycle counts as the handshake. A requester may present its next request in the following cycle; it is not considered until the FSM returns to IDLE.
- ram_byteen is forced to 4'hf on reads.
- Reset mid-access: the access is abandoned and RAM strobes drop immediately. No rsp_valid is sent.
- Arbitration (default): fixed priority, lowest index wins.

Optional Feature:
RAM_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at (last-grant pointer + 1) mod NREQ, skipping ineligible requesters. The pointer updates to w on each grant.
- Undefined: fixed priority; the pointer register is not built.

Decomposition:
- Shared const.v package holds: `RAM_ADDR_BITS, `RAM_ADDR_MAX, the FSM state encodings (ARB_IDLE, ARB_ISSUE, ARB_WAIT_RD, ARB_RESP, 2 bits), and requester index constants (REQ_INIT=0, REQ_LOAD=1, REQ_DFETCH=2, REQ_IFETCH=3).
- One sub-module is natural: ram_arb_pick. It is combinational and takes eligible vector + pointer, returning a one-hot winner and a valid flag. It implements both fixed and round-robin modes under the macro.

Test Plan:
- Single write, then read back: requester 1 writes addr 5 = 32'hdead0005, then reads addr 5 → ram_wren 1 cycle with addr 5; later rsp_valid[1] with rsp_rddata=32'hdead0005, exactly RD_LAT+1 cycles after req_ready.
- Contention: all four requesters assert read in the same cycle, fixed priority → grants in order 0,1,2,3. Each rsp_valid goes only to its owner, and no two accesses overlap.
- Round-robin (RAM_ARB_RR_EN): requesters 0 and 2 request continuously → grants alternate 0,2,0,2; neither waits more than one access.
- Masking: req_mask=4'b0001 with requests on 0 and 3 → only 0 is served; requester 3 is served once the mask is set to 4'b1000.
- Withdraw and reset: requester 2 drops req_valid while 0 is busy → no req_ready[2]. Assert rst low during WAIT_RD → all outputs 0 asynchronously, and no rsp_valid after release.
- Latency sweep: RD_LAT=1,2,3 → read occupancy of 3, 4, 5 cycles respectively; busy is low for exactly one cycle between back-to-back grants.
